// File: rtl/abc_keystream_core.sv
// ABC-style keystream core: W-bit LFSR s0..s3, keyed accumulator x, keyed output map.
// Word-serial key/IV load, fixed warm-up, then back-pressured keystream output.
module abc_keystream_core #(
    parameter int W      = 32,
    parameter int WARMUP = 32,
    parameter int ROT    = W / 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] key_data,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [W-1:0] ks_data,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_WARM = 2'd2;
    localparam logic [1:0] ST_RUN  = 2'd3;
    localparam logic [7:0] WC_LAST = 8'(WARMUP - 1);

    logic [1:0]   state_q, state_d;
    logic [2:0]   lc_q, lc_d;
    logic [7:0]   wc_q, wc_d;
    logic [W-1:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [W-1:0] x_q, x_d, k0_q, k0_d, k1_q, k1_d, k2_q, k2_d;
    logic [W-1:0] ks_data_q, ks_data_d;
    logic         ks_valid_q, ks_valid_d;

    logic [W-1:0] fb, x_step, x_rot, y;
    logic         do_step;

    always_comb begin
        fb     = s0_q ^ (s1_q << 3) ^ (s3_q >> 5);
        x_step = x_q + s0_q + ((x_q ^ k0_q) + k1_q);
        x_rot  = (x_q << ROT) | (x_q >> (W - ROT));
        y      = (x_rot ^ k2_q) + s3_q;
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no branch can leave a latch behind.
        state_d    = state_q;
        lc_d       = lc_q;
        wc_d       = wc_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        s3_d       = s3_q;
        x_d        = x_q;
        k0_d       = k0_q;
        k1_d       = k1_q;
        k2_d       = k2_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        do_step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    s0_d    = key_data;
                    lc_d    = 3'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (key_valid) begin
                    lc_d = lc_q + 3'd1;
                    case (lc_q)
                        3'd1:    s1_d = key_data;
                        3'd2:    s2_d = key_data;
                        3'd3:    s3_d = key_data;
                        3'd4:    x_d  = key_data;
                        3'd5:    k0_d = key_data;
                        3'd6:    k1_d = key_data;
                        3'd7:    k2_d = key_data;
                        default: ;
                    endcase
                    if (lc_q == 3'd7) begin
                        // An all-zero LFSR would lock up; s0..s3 are final by the last beat.
                        if ((s0_q | s1_q | s2_q | s3_q) == '0) s0_d = W'(1);
                        wc_d    = '0;
                        state_d = (WARMUP == 0) ? ST_RUN : ST_WARM;
                    end
                end
            end
            ST_WARM: begin
                do_step = 1'b1;
                wc_d    = wc_q + 8'd1;
                if (wc_q == WC_LAST) state_d = ST_RUN;
            end
            default: begin
                if (key_valid) begin
                    s0_d       = key_data;
                    lc_d       = 3'd1;
                    ks_valid_d = 1'b0;
                    state_d    = ST_LOAD;
                end else if (!ks_valid_q || ks_ready) begin
                    do_step    = 1'b1;
                    ks_data_d  = y;
                    ks_valid_d = 1'b1;
                end
            end
        endcase

        if (do_step) begin
            s0_d = s1_q;
            s1_d = s2_q;
            s2_d = s3_q;
            s3_d = fb;
            x_d  = x_step;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            lc_q       <= '0;
            wc_q       <= '0;
            s0_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            x_q        <= '0;
            k0_q       <= '0;
            k1_q       <= '0;
            k2_q       <= '0;
            ks_data_q  <= '0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lc_q       <= lc_d;
            wc_q       <= wc_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            x_q        <= x_d;
            k0_q       <= k0_d;
            k1_q       <= k1_d;
            k2_q       <= k2_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    assign key_ready = (state_q != ST_WARM);
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_WARM);
    assign ks_data   = ks_data_q;
    assign ks_valid  = ks_valid_q;

endmodule

// File: tb/tb_abc_keystream_core.sv
// Bench for abc_keystream_core: a 32-bit/WARMUP=32 instance and an 8-bit/WARMUP=0/ROT=3
// instance, both checked against a word-level model of the cipher recurrences.
module tb_abc_keystream_core;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] key_data;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] ks_data;
    logic        ks_valid;
    logic        ks_ready;
    logic        busy;
    logic [7:0]  key_data8;
    logic        key_valid8;
    logic        key_ready8;
    logic [7:0]  ks_data8;
    logic        ks_valid8;
    logic        ks_ready8;
    logic        busy8;

    int total = 0;
    int bad   = 0;

    bit [63:0] m_s[4];
    bit [63:0] m_x;
    bit [63:0] m_k[3];
    bit [63:0] kw[8];

    always #5 clock = ~clock;

    abc_keystream_core #(.W(32), .WARMUP(32), .ROT(16)) dut (
        .clock(clock), .reset(reset),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready), .busy(busy)
    );

    abc_keystream_core #(.W(8), .WARMUP(0), .ROT(3)) dut8 (
        .clock(clock), .reset(reset),
        .key_data(key_data8), .key_valid(key_valid8), .key_ready(key_ready8),
        .ks_data(ks_data8), .ks_valid(ks_valid8), .ks_ready(ks_ready8), .busy(busy8)
    );

    function automatic bit [63:0] mask(input int w);
        bit [63:0] m;
        m = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return m;
    endfunction

    // Model: key words kw[] -> cipher state, with the all-zero LFSR guard.
    task automatic m_seed(input int w);
        for (int i = 0; i < 4; i++) m_s[i] = kw[i] & mask(w);
        m_x = kw[4] & mask(w);
        for (int i = 0; i < 3; i++) m_k[i] = kw[5 + i] & mask(w);
        if (m_s[0] == 0 && m_s[1] == 0 && m_s[2] == 0 && m_s[3] == 0) m_s[0] = 64'd1;
    endtask

    task automatic m_next(input int w, input int rot, output bit [63:0] y);
        bit [63:0] m;
        bit [63:0] r;
        bit [63:0] fb;
        bit [63:0] xn;
        m  = mask(w);
        r  = ((m_x << rot) | (m_x >> (w - rot))) & m;
        y  = ((r ^ m_k[2]) + m_s[3]) & m;
        fb = (m_s[0] ^ (m_s[1] << 3) ^ (m_s[3] >> 5)) & m;
        xn = (m_x + m_s[0] + ((m_x ^ m_k[0]) + m_k[1])) & m;
        m_s[0] = m_s[1];
        m_s[1] = m_s[2];
        m_s[2] = m_s[3];
        m_s[3] = fb;
        m_x    = xn;
    endtask

    task automatic m_warm32();
        bit [63:0] d;
        for (int i = 0; i < 32; i++) m_next(32, 16, d);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        key_valid  = 1'b0;
        key_valid8 = 1'b0;
        key_data   = '0;
        key_data8  = '0;
        ks_ready   = 1'b1;
        ks_ready8  = 1'b1;
        reset      = 1'b0;
        #12;
        reset = 1'b1;
        tick();
    endtask

    task automatic load32(input bit gaps);
        for (int i = 0; i < 8; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                key_valid = 1'b0;
                tick();
            end
            key_valid = 1'b1;
            key_data  = kw[i][31:0];
            total++;
            if (key_ready !== 1'b1) begin
                bad++;
                $display("FAIL load_ready beat=%0d got=%b want=1", i, key_ready);
            end
            tick();
        end
        key_valid = 1'b0;
    endtask

    task automatic wait_valid32(input int budget);
        int n;
        n = 0;
        while (ks_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (ks_valid !== 1'b1) begin
            bad++;
            $display("FAIL wait_valid timeout got=%b want=1 after %0d cycles", ks_valid, n);
        end
    endtask

    task automatic expect_words32(input int count, input string tag);
        bit [63:0] y;
        for (int i = 0; i < count; i++) begin
            m_next(32, 16, y);
            total++;
            if (ks_valid !== 1'b1 || ks_data !== y[31:0]) begin
                bad++;
                $display("FAIL %s word=%0d got=%h/%b want=%h/1", tag, i, ks_data, ks_valid, y[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        key_valid  = 1'b0;
        key_valid8 = 1'b0;
        key_data   = '0;
        key_data8  = '0;
        ks_ready   = 1'b1;
        ks_ready8  = 1'b1;
        #1 reset = 1'b0;
        #2;
        total++;
        if (ks_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0 || ks_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_values got v=%b r=%b b=%b d=%h want 0 1 0 0", ks_valid, key_ready, busy, ks_data);
        end
        #10 reset = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1;
            key_data  = $urandom;
            tick();
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL partial_load_busy got=%b want=1", busy);
        end
        #3 reset = 1'b0;
        #1;
        total++;
        if (ks_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got v=%b r=%b b=%b want 0 1 0", ks_valid, key_ready, busy);
        end
        key_valid = 1'b0;
        #10 reset = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1;
            key_data  = $urandom;
            tick();
        end
        key_valid = 1'b0;
        repeat (60) tick();
        total++;
        if (ks_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL partial_lost got v=%b b=%b want v=0 b=1", ks_valid, busy);
        end
    endtask

    task automatic test_nominal();
        int edges;
        int busy_cycles;
        do_reset();
        kw = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd0, 64'd0, 64'd0, 64'd0};
        m_seed(32);
        m_warm32();
        edges       = 0;
        busy_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            key_valid = 1'b1;
            key_data  = kw[i][31:0];
            if ((key_valid && key_ready) || busy) busy_cycles++;
            tick();
            edges++;
        end
        key_valid = 1'b0;
        while (ks_valid !== 1'b1 && edges < 100) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        total++;
        if (edges !== 41) begin
            bad++;
            $display("FAIL first_valid_latency got=%0d want=41", edges);
        end
        total++;
        if (busy_cycles !== 40) begin
            bad++;
            $display("FAIL busy_cycles got=%0d want=40", busy_cycles);
        end
        expect_words32(16, "nominal");
    endtask

    task automatic test_zero_guard();
        do_reset();
        for (int i = 0; i < 8; i++) kw[i] = 64'd0;
        load32(1'b0);
        total++;
        if (dut.s0_q !== 32'd1) begin
            bad++;
            $display("FAIL zero_guard_s0 got=%h want=00000001", dut.s0_q);
        end
        m_seed(32);
        m_warm32();
        wait_valid32(100);
        expect_words32(8, "zero_guard");
    endtask

    task automatic test_back_pressure();
        bit [63:0]   y;
        bit          prev_stall;
        logic [31:0] prev_data;
        int          hs;
        do_reset();
        for (int i = 0; i < 8; i++) kw[i] = {32'd0, $urandom};
        load32(1'b1);
        m_seed(32);
        m_warm32();
        prev_stall = 1'b0;
        prev_data  = '0;
        hs         = 0;
        for (int c = 0; c < 240; c++) begin
            ks_ready = ($urandom_range(0, 1) == 1);
            if (prev_stall) begin
                total++;
                if (ks_valid !== 1'b1 || ks_data !== prev_data) begin
                    bad++;
                    $display("FAIL stall_hold cyc=%0d got=%h/%b want=%h/1", c, ks_data, ks_valid, prev_data);
                end
            end
            if (ks_valid === 1'b1 && ks_ready) begin
                m_next(32, 16, y);
                hs++;
                total++;
                if (ks_data !== y[31:0]) begin
                    bad++;
                    $display("FAIL bp_word n=%0d got=%h want=%h", hs, ks_data, y[31:0]);
                end
            end
            prev_stall = (ks_valid === 1'b1) && !ks_ready;
            prev_data  = ks_data;
            tick();
        end
        total++;
        if (hs < 50) begin
            bad++;
            $display("FAIL bp_handshakes got=%0d want>=50", hs);
        end
    endtask

    task automatic test_reload();
        ks_ready = 1'b0;
        wait_valid32(100);
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL run_key_ready got=%b want=1", key_ready);
        end
        for (int i = 0; i < 8; i++) kw[i] = {32'd0, $urandom};
        key_valid = 1'b1;
        key_data  = kw[0][31:0];
        tick();
        total++;
        if (ks_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL reload_clear got v=%b b=%b want v=0 b=1", ks_valid, busy);
        end
        for (int i = 1; i < 8; i++) begin
            key_data = kw[i][31:0];
            tick();
        end
        key_valid = 1'b0;
        m_seed(32);
        m_warm32();
        ks_ready = 1'b1;
        wait_valid32(100);
        expect_words32(8, "reload");
    endtask

    task automatic test_params();
        bit [63:0] y;
        do_reset();
        for (int i = 0; i < 8; i++) kw[i] = 64'hA5;
        for (int i = 0; i < 8; i++) begin
            key_valid8 = 1'b1;
            key_data8  = 8'hA5;
            tick();
        end
        key_valid8 = 1'b0;
        total++;
        if (ks_valid8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL w8_after_load got v=%b b=%b want 0 0", ks_valid8, busy8);
        end
        tick();
        total++;
        if (ks_valid8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_first_valid got=%b want=1", ks_valid8);
        end
        m_seed(8);
        for (int i = 0; i < 32; i++) begin
            m_next(8, 3, y);
            total++;
            if (ks_valid8 !== 1'b1 || ks_data8 !== y[7:0]) begin
                bad++;
                $display("FAIL w8_word n=%0d got=%h/%b want=%h/1", i, ks_data8, ks_valid8, y[7:0]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_zero_guard();
        test_back_pressure();
        test_reload();
        test_params();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
